// File: rtl/config_usb_pkg.sv
// Shared types and constants for the configuration-over-USB bridge.
package config_usb_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ACK_TX = 2'd2
  } state_t;

  localparam logic [23:0] HEADER_SYNC       = 24'h00AAFF;
  localparam int unsigned DESYNC_FLAG_POS   = 20;
  localparam logic [31:0] DEFAULT_ACK_FRAME = 32'hFAB0_FABF;
  localparam int unsigned ACK_BYTES         = 6;
  localparam int unsigned ACK_FRAME_W       = 8 * ACK_BYTES;

  // Command byte that opens a load: low seven bits equal 1 or 2, bit 7 ignored.
  function automatic logic is_load_cmd(input logic [7:0] b);
    return ((b & 8'h7F) == 8'h01) || ((b & 8'h7F) == 8'h02);
  endfunction

endpackage

// File: rtl/config_usb_ack_tx.sv
// Serialises a 48-bit acknowledge frame MSB-first over a valid/ready byte stream.
module config_usb_ack_tx
  import config_usb_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start,
  input  logic [ACK_FRAME_W-1:0] frame,
  input  logic                   in_ready_i,
  output logic [7:0]             in_data_o,
  output logic                   in_valid_o,
  output logic                   done_c
);

  localparam int unsigned REST_W = ACK_FRAME_W - 8;

  logic [REST_W-1:0] rest_q;
  logic [2:0]        sent_q;
  logic              take;

  assign take   = in_valid_o && in_ready_i;
  assign done_c = take && (sent_q == 3'(ACK_BYTES - 1));

  // Next byte is loaded on the acceptance edge so bytes go out back to back.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      in_data_o  <= 8'h00;
      in_valid_o <= 1'b0;
      rest_q     <= '0;
      sent_q     <= 3'd0;
    end else if (start) begin
      in_data_o  <= frame[ACK_FRAME_W-1 -: 8];
      in_valid_o <= 1'b1;
      rest_q     <= frame[REST_W-1:0];
      sent_q     <= 3'd0;
    end else if (take) begin
      if (done_c) begin
        in_data_o  <= 8'h00;
        in_valid_o <= 1'b0;
        rest_q     <= '0;
        sent_q     <= 3'd0;
      end else begin
        in_data_o <= rest_q[REST_W-1 -: 8];
        rest_q    <= {rest_q[REST_W-9:0], 8'h00};
        sent_q    <= sent_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/config_usb_bridge.sv
// Byte-stream to configuration-word bridge: header hunt, word assembly with
// inter-byte timeout, and an acknowledge frame on the desync word.
module config_usb_bridge
  import config_usb_pkg::*;
#(
  parameter int unsigned WORD_BYTES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [31:0] ACK_FRAME      = DEFAULT_ACK_FRAME
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [7:0]              out_data_i,
  input  logic                    out_valid_i,
  output logic                    out_ready_o,
  output logic [7:0]              in_data_o,
  output logic                    in_valid_o,
  input  logic                    in_ready_i,
  output logic                    word_write_strobe_o,
  output logic [8*WORD_BYTES-1:0] write_data_o,
  output logic                    active_o,
  output logic                    timeout_err_o,
  output logic [15:0]             word_count_o
);

  localparam int unsigned W     = 8 * WORD_BYTES;
  localparam int unsigned GAP_W = 32;
  localparam logic [W-1:0] DESYNC_WORD =
    (W > DESYNC_FLAG_POS) ? W'(64'd1 << DESYNC_FLAG_POS) : '0;

  state_t             state_q, state_d;
  logic [23:0]        hdr_q, hdr_d;
  logic [W-1:0]       buf_q, buf_d;
  logic [2:0]         idx_q, idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               strobe_d, err_d, active_d, ready_d;
  logic [W-1:0]       wdata_d;
  logic [15:0]        count_d;

  logic               accept;
  logic               hdr_hit;
  logic               last_byte;
  logic               timeout_hit;
  logic [W-1:0]       word_next;
  logic [15:0]        count_inc;
  logic               ack_start;
  logic               ack_done_c;
  logic [ACK_FRAME_W-1:0] ack_frame;

  assign accept      = out_valid_i && out_ready_o;
  // The header window is the three stored bytes plus the byte being accepted.
  assign hdr_hit     = (hdr_q == HEADER_SYNC) && is_load_cmd(out_data_i);
  assign last_byte   = (idx_q == 3'(WORD_BYTES - 1));
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));
  assign word_next   = W'({buf_q, out_data_i});
  assign count_inc   = (word_count_o == 16'hFFFF) ? word_count_o
                                                  : word_count_o + 16'd1;
  assign ack_frame   = {ACK_FRAME, count_inc};

  config_usb_ack_tx u_ack_tx (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .start      (ack_start),
    .frame      (ack_frame),
    .in_ready_i (in_ready_i),
    .in_data_o  (in_data_o),
    .in_valid_o (in_valid_o),
    .done_c     (ack_done_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    buf_d     = buf_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    strobe_d  = 1'b0;
    wdata_d   = write_data_o;
    count_d   = word_count_o;
    err_d     = timeout_err_o;
    ack_start = 1'b0;

    unique case (state_q)
      ST_HUNT: begin
        if (accept) begin
          if (hdr_hit) begin
            state_d = ST_LOAD;
            hdr_d   = '0;
            buf_d   = '0;
            idx_d   = 3'd0;
            gap_d   = '0;
            count_d = 16'd0;
            err_d   = 1'b0;
          end else begin
            hdr_d = {hdr_q[15:0], out_data_i};
          end
        end
      end

      ST_LOAD: begin
        if (accept) begin
          gap_d = '0;
          if (last_byte) begin
            idx_d    = 3'd0;
            buf_d    = '0;
            wdata_d  = word_next;
            strobe_d = 1'b1;
            count_d  = count_inc;
            if (word_next == DESYNC_WORD) begin
              state_d   = ST_ACK_TX;
              ack_start = 1'b1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
            buf_d = word_next;
          end
        end else if (timeout_hit) begin
          // Partial word is dropped; a byte on the same cycle would have won.
          state_d = ST_HUNT;
          idx_d   = 3'd0;
          buf_d   = '0;
          gap_d   = '0;
          err_d   = 1'b1;
        end else if (TIMEOUT_CYCLES != 0) begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      ST_ACK_TX: begin
        if (ack_done_c) begin
          state_d = ST_HUNT;
        end
      end

      default: begin
        state_d = ST_HUNT;
      end
    endcase

    ready_d  = (state_d != ST_ACK_TX);
    active_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q             <= ST_HUNT;
      hdr_q               <= '0;
      buf_q               <= '0;
      idx_q               <= 3'd0;
      gap_q               <= '0;
      word_write_strobe_o <= 1'b0;
      write_data_o        <= '0;
      word_count_o        <= 16'd0;
      timeout_err_o       <= 1'b0;
      active_o            <= 1'b0;
      out_ready_o         <= 1'b1;
    end else begin
      state_q             <= state_d;
      hdr_q               <= hdr_d;
      buf_q               <= buf_d;
      idx_q               <= idx_d;
      gap_q               <= gap_d;
      word_write_strobe_o <= strobe_d;
      write_data_o        <= wdata_d;
      word_count_o        <= count_d;
      timeout_err_o       <= err_d;
      active_o            <= active_d;
      out_ready_o         <= ready_d;
    end
  end

endmodule
